iir_out_buffer: RTL and testbench
=================================

Name: iir_out_buffer

Overview:
- Elastic output stage directly downstream of iir_filter.
- Captures every filtered sample presented on the filter's dOut/vOut pair into a small FIFO and re-presents it on a valid/ready interface, so a consumer such as a bus, serializer or data_sink can stall.
- iir_filter has no backpressure input. Samples that arrive while the buffer is full are dropped, counted and flagged.

Parameters:
- NB, 12, sample width in bits; matches the iir_filter NB.
- DEPTH, 8, FIFO depth in samples; must be a power of 2 and at least 2.
- AW, log2(DEPTH) = 3, pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vIn  in  1  input sample valid, from iir_filter vOut.
- dIn  in  NB  input sample, signed two's complement, from iir_filter dOut.
- rdy  in  1  consumer ready.
- dOut  out  NB  head-of-FIFO sample.
- vOut  out  1  head sample valid; high exactly when the FIFO is not empty.
- level  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  high when level equals DEPTH.
- ovf  out  1  sticky overflow flag.
- drop_cnt  out  8  count of dropped samples; saturates at 255.
- clr_ovf  in  1  synchronous clear for ovf and drop_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, level=0, vOut=0, dOut=0, full=0, ovf=0, drop_cnt=0. FIFO contents are discarded. Reset asserted mid-stream drops everything with no partial pop.
- Release of reset is synchronised into the design by the codebase's standard reset release. The first push is possible on the first clock edge with rst_n=1.
- Read side is first-word-fall-through: dOut = mem[rd_ptr] when vOut=1, and 0 when vOut=0.
- pop = vOut & rdy.
- push = vIn & (~full | pop). A write to a full FIFO is accepted only when a pop occurs in the same cycle.
- Latency: a sample pushed at edge N is visible on dOut with vOut=1 after edge N, provided the FIFO was empty. Otherwise it follows in FIFO order.
- Push on the empty FIFO is push only. vOut=0, so no pop is possible and there is no write-through bypass.
- Pointers are AW bits and wrap modulo DEPTH. level is updated as follows:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or on neither.
- full is registered and equals (level==DEPTH) after each edge.
- Drop: when vIn=1, full=1 and pop=0, the sample is discarded and FIFO state is unchanged. On that edge ovf is set to 1 and drop_cnt increments, saturating at 255.
- clr_ovf=1 clears ovf to 0 and drop_cnt to 0 on the edge.
- If clr_ovf=1 and a drop occur on the same edge, the drop wins: ovf=1 and drop_cnt=1.
- rdy while vOut=0 has no effect.
- The consumer may hold rdy=0 indefinitely. dOut and vOut must stay stable while vOut=1 and rdy=0.
- No combinational path from rdy to any output except through level/full after the edge. vOut and dOut do not depend on rdy combinationally.
- dIn is stored bit-exact, with no sign manipulation.

Decomposition:
- Shared package iir_pkg holds:
  - NB=12
  - DEPTH_DEFAULT=8
  - the sample typedef (signed [NB-1:0])
  - a clog2 function used for AW.
- One natural sub-module, iir_buf_mem:
  - DEPTH x NB register file
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - no reset on the storage array.
- Pointer, level and flag logic stay in the top module.

Test Plan:
- Reset: during and after rst_n=0, all outputs are 0. Assert rst_n=0 asynchronously mid-cycle with level=5; level=0 and vOut=0 immediately, without waiting for an edge.
- Pass-through: rdy=1 constant; push 0x001, 0x7FF, 0x800, 0xFFF on consecutive cycles. dOut shows the same sequence, one cycle after each push, with vOut=1. level stays at most 1, ovf=0.
- Fill and drain: rdy=0, push 8 samples 0x010..0x017; full=1 and level=8. Then rdy=1 with no input; dOut=0x010..0x017 in order, then vOut=0 and dOut=0. Pointer wrap is exercised by repeating the sequence twice.
- Overflow: rdy=0, push 11 samples; 3 are dropped, ovf=1, drop_cnt=3, and stored contents are the first 8 samples. Then pulse clr_ovf; ovf=0, drop_cnt=0.
- Full with simultaneous push and pop: FIFO full, vIn=1 and rdy=1 together. The push is accepted, level stays 8, no drop, and the new sample appears last in order.
- Clear collides with drop: same edge has clr_ovf=1 and a drop. Result ovf=1, drop_cnt=1.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the iir_filter datapath and its output buffer.
package iir_pkg;

    localparam int NB            = 12;
    localparam int DEPTH_DEFAULT = 8;

    typedef logic signed [NB-1:0] sample_t;

    // Ceiling log2 for elaboration-time pointer widths (returns 1 for v <= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/iir_buf_mem.sv
// DEPTH x NB register file: one synchronous write port, one asynchronous read port.
// Storage has no reset; occupancy tracking in the parent decides what is valid.
module iir_buf_mem
    import iir_pkg::*;
#(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] mem [DEPTH];

    // Sample write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_buffer.sv
// Elastic first-word-fall-through output buffer behind iir_filter.
// The filter cannot be stalled, so samples arriving while full are dropped,
// counted (saturating) and flagged with a sticky overflow bit.
module iir_out_buffer
    import iir_pkg::*;
#(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vIn,
    input  logic [NB-1:0] dIn,
    input  logic          rdy,
    output logic [NB-1:0] dOut,
    output logic          vOut,
    output logic [AW:0]   level,
    output logic          full,
    output logic          ovf,
    output logic [7:0]    drop_cnt,
    input  logic          clr_ovf
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          push, pop, drop;
    logic [NB-1:0] rdata;

    // vOut derives only from registered occupancy, keeping rdy off every output path.
    assign vOut     = (level_q != '0);
    assign dOut     = vOut ? rdata : '0;
    assign level    = level_q;
    assign full     = full_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    iir_buf_mem #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (dIn),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Next-state for pointers, occupancy and overflow bookkeeping.
    always_comb begin
        pop        = vOut & rdy;
        push       = vIn & (~full_q | pop);
        drop       = vIn & full_q & ~pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_FULL);

        // A drop on the same edge as a clear wins: the clear still zeroes the
        // old count, then this drop is counted as the first.
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = clr_ovf ? 8'd1
                       : (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
        end else if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // State registers; asynchronous reset discards everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed bench for iir_out_buffer: the driver pushes expected samples into a
// scoreboard queue; a negedge monitor pops and compares on every handshake.
module tb_iir_out_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vIn = 1'b0;
    logic [11:0] dIn = '0;
    logic        rdy = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [11:0] dOut;
    logic        vOut;
    logic [3:0]  level;
    logic        full;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [11:0] sb [$];

    iir_out_buffer dut (
        .clk(clk), .rst_n(rst_n), .vIn(vIn), .dIn(dIn), .rdy(rdy),
        .dOut(dOut), .vOut(vOut), .level(level), .full(full),
        .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample for one cycle; record it as expected only if it will be stored.
    task automatic send(input logic [11:0] v, input bit stored);
        vIn = 1'b1;
        dIn = v;
        if (stored) sb.push_back(v);
        step();
        vIn = 1'b0;
        dIn = '0;
    endtask

    // Monitor: every accepted pop must match the scoreboard head; idle dOut must be 0.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vOut && rdy) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    check("pop_data", int'(dOut), int'(sb.pop_front()));
                end
            end else if (!vOut) begin
                check("idle_dout_zero", int'(dOut), 0);
            end
        end
    end

    initial begin
        // Reset state
        step(); step();
        check("rst_vout", vOut, 0);
        check("rst_dout", dOut, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        // Pass-through with constant ready
        rdy = 1'b1;
        begin
            logic [11:0] pt [4];
            pt = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
            for (int i = 0; i < 4; i++) begin
                send(pt[i], 1'b1);
                check("pt_level", level, 1);
                check("pt_vout", vOut, 1);
                check("pt_dout", dOut, pt[i]);
            end
        end
        step();
        check("pt_empty", level, 0);
        check("pt_ovf", ovf, 0);

        // Fill and drain, twice to wrap the pointers
        for (int rep = 0; rep < 2; rep++) begin
            rdy = 1'b0;
            for (int i = 0; i < 8; i++) send(12'h010 + 12'(i), 1'b1);
            check("fill_full", full, 1);
            check("fill_level", level, 8);
            check("fill_head", dOut, 12'h010);
            rdy = 1'b1;
            for (int i = 0; i < 8; i++) step();
            check("drain_vout", vOut, 0);
            check("drain_dout", dOut, 0);
            check("drain_level", level, 0);
            check("drain_full", full, 0);
        end

        // Overflow: 11 pushes into 8 slots
        rdy = 1'b0;
        for (int i = 0; i < 11; i++) send(12'h100 + 12'(i), i < 8);
        check("ovf_flag", ovf, 1);
        check("ovf_cnt", drop_cnt, 3);
        check("ovf_level", level, 8);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_flag", ovf, 0);
        check("clr_cnt", drop_cnt, 0);

        // Full with simultaneous push and pop: accepted, queued last
        rdy = 1'b1;
        send(12'h200, 1'b1);
        check("fpp_level", level, 8);
        check("fpp_ovf", ovf, 0);
        check("fpp_cnt", drop_cnt, 0);
        check("fpp_full", full, 1);

        // Clear colliding with a drop
        rdy = 1'b0;
        clr_ovf = 1'b1;
        send(12'h300, 1'b0);
        clr_ovf = 1'b0;
        check("coll_flag", ovf, 1);
        check("coll_cnt", drop_cnt, 1);
        check("coll_level", level, 8);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) send(12'h3FF, 1'b0);
        check("sat_cnt", drop_cnt, 255);
        check("sat_level", level, 8);

        // Drain: 0x101..0x107 then 0x200
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("ovf_drain_level", level, 0);
        check("ovf_drain_sb", sb.size(), 0);
        check("ovf_drain_cnt_sticky", drop_cnt, 255);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Mid-stream asynchronous reset with level=5
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(12'h0A0 + 12'(i), 1'b1);
        check("mid_level", level, 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_level", level, 0);
        check("async_vout", vOut, 0);
        check("async_dout", dOut, 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        rdy = 1'b1;
        send(12'h555, 1'b1);
        check("post_rst_vout", vOut, 1);
        check("post_rst_dout", dOut, 12'h555);
        step();
        check("post_rst_level", level, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
